// File: rtl/esc_quad_pwm.sv
// esc_quad_pwm: four-channel ESC pulse generator with a frame-aligned arming sequence.
// Every state, speed and width update happens only at the frame wrap.
module esc_quad_pwm #(
   parameter int FRAME_CLKS = 125000,
   parameter int MIN_PULSE  = 50000,
   parameter int ARM_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        spd_vld,
   input  logic [10:0] frnt_spd,
   input  logic [10:0] bck_spd,
   input  logic [10:0] lft_spd,
   input  logic [10:0] rght_spd,
   output logic        pwm_frnt,
   output logic        pwm_bck,
   output logic        pwm_lft,
   output logic        pwm_rght,
   output logic        frame_tick,
   output logic        armed
);
   typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;
   state_t state, state_nxt;
   logic [16:0] cnt, cnt_nxt;
   logic [7:0] arm_cnt, arm_cnt_nxt;
   logic [3:0][10:0] spd, stage, act, act_nxt;
   logic [3:0][16:0] width, width_nxt;
   logic [3:0] pwm, pwm_nxt;
   logic bnd;
   assign spd = {rght_spd, lft_spd, bck_spd, frnt_spd};
   always_comb begin
      bnd = cnt == 17'(FRAME_CLKS - 1);
      cnt_nxt = bnd ? '0 : cnt + 17'd1;
      state_nxt = state;
      arm_cnt_nxt = arm_cnt;
      if (bnd)
         case (state)
            DISARMED: if (arm) begin
               state_nxt = ARMING;
               arm_cnt_nxt = '0;
            end
            ARMING: if (!arm) state_nxt = DISARMED;
               else if (arm_cnt == 8'(ARM_FRAMES - 1)) state_nxt = ARMED;
               else arm_cnt_nxt = arm_cnt + 8'd1;
            ARMED: if (!arm) state_nxt = DISARMED;
            default: state_nxt = DISARMED;
         endcase
      // pwm is registered from next-cycle values so it lines up with cnt
      for (int i = 0; i < 4; i++) begin
         act_nxt[i] = bnd ? (spd_vld ? spd[i] : stage[i]) : act[i];
         width_nxt[i] = !bnd ? width[i] :
                        state_nxt == ARMED  ? 17'(MIN_PULSE) + 17'(act_nxt[i]) * 17'd3 :
                        state_nxt == ARMING ? 17'(MIN_PULSE) : '0;
         pwm_nxt[i] = cnt_nxt < width_nxt[i];
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         state <= DISARMED;
         arm_cnt <= '0;
         stage <= '0;
         act <= '0;
         width <= '0;
         pwm <= '0;
      end else begin
         cnt <= cnt_nxt;
         state <= state_nxt;
         arm_cnt <= arm_cnt_nxt;
         if (spd_vld) stage <= spd;
         act <= act_nxt;
         width <= width_nxt;
         pwm <= pwm_nxt;
      end
   assign {pwm_rght, pwm_lft, pwm_bck, pwm_frnt} = pwm;
   assign frame_tick = (cnt == '0) & ~rst;
   assign armed = state == ARMED;
endmodule

// File: tb/tb_esc_quad_pwm.sv
// tb_esc_quad_pwm: frame-level reference model checking pulse widths, tick period and arming.
module tb_esc_quad_pwm;
   localparam int AF = 2;
   localparam int MINP = 20;
   logic clk = 0, rst, arm, spd_vld;
   logic [10:0] frnt, bck, lft, rght;
   logic pfa, pba, pla, pra, ta, aa;
   logic pfb, pbb, plb, prb, tb, ab;
   logic [3:0] pw;
   logic tick, armd;
   bit sel;
   int checks = 0, errors = 0;
   int nb;
   int stg[4], act_m[4], ew[4], sv[4];
   string nm[4] = '{"frnt", "bck", "lft", "rght"};

   esc_quad_pwm #(.FRAME_CLKS(200), .MIN_PULSE(MINP), .ARM_FRAMES(AF)) u_a (
      .clk(clk), .rst(rst), .arm(arm), .spd_vld(spd_vld),
      .frnt_spd(frnt), .bck_spd(bck), .lft_spd(lft), .rght_spd(rght),
      .pwm_frnt(pfa), .pwm_bck(pba), .pwm_lft(pla), .pwm_rght(pra),
      .frame_tick(ta), .armed(aa));
   esc_quad_pwm #(.FRAME_CLKS(8000), .MIN_PULSE(MINP), .ARM_FRAMES(AF)) u_b (
      .clk(clk), .rst(rst), .arm(arm), .spd_vld(spd_vld),
      .frnt_spd(frnt), .bck_spd(bck), .lft_spd(lft), .rght_spd(rght),
      .pwm_frnt(pfb), .pwm_bck(pbb), .pwm_lft(plb), .pwm_rght(prb),
      .frame_tick(tb), .armed(ab));

   always #5 clk = ~clk;
   assign pw = sel ? {prb, plb, pbb, pfb} : {pra, pla, pba, pfa};
   assign tick = sel ? tb : ta;
   assign armd = sel ? ab : aa;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      nb = 0;
      for (int i = 0; i < 4; i++) begin
         stg[i] = 0;
         act_m[i] = 0;
         ew[i] = 0;
      end
   endtask

   // nb = consecutive boundaries that saw arm high; the first AF are the arming frames
   task automatic model_boundary();
      nb = arm ? nb + 1 : 0;
      for (int i = 0; i < 4; i++) begin
         act_m[i] = stg[i];
         ew[i] = nb == 0 ? 0 : nb <= AF ? MINP : MINP + 3 * act_m[i];
      end
   endtask

   task automatic drive_sv();
      frnt = 11'(sv[0]);
      bck = 11'(sv[1]);
      lft = 11'(sv[2]);
      rght = 11'(sv[3]);
      for (int i = 0; i < 4; i++) stg[i] = sv[i];
   endtask

   // Entered at the negedge of a cnt=0 cycle; leaves at the next frame's cnt=0 negedge.
   task automatic run_frame(input int arm_pos, input bit new_arm, input int sp, input bit garbage);
      int f;
      int hi[4];
      bit lo[4], bad[4];
      int tick_bad;
      f = sel ? 8000 : 200;
      tick_bad = 0;
      for (int i = 0; i < 4; i++) begin
         hi[i] = 0;
         lo[i] = 0;
         bad[i] = 0;
      end
      check("armed", int'(armd), int'(nb > AF));
      for (int k = 0; k < f; k++) begin
         if (k > 0) @(negedge clk);
         if (tick !== (k == 0)) tick_bad++;
         for (int i = 0; i < 4; i++)
            if (pw[i] === 1'b1) begin
               if (lo[i]) bad[i] = 1;
               hi[i]++;
            end else lo[i] = 1;
         if (garbage && k == 0) begin
            frnt = 11'($urandom);
            bck = 11'($urandom);
            lft = 11'($urandom);
            rght = 11'($urandom);
         end
         spd_vld = (k == sp);
         if (k == sp) drive_sv();
         if (k == arm_pos) arm = new_arm;
      end
      check("tick_pos", tick_bad, 0);
      for (int i = 0; i < 4; i++)
         check($sformatf("width_%s", nm[i]), bad[i] ? -1 : hi[i], ew[i] < f ? ew[i] : f);
      model_boundary();
      @(negedge clk);
      spd_vld = 0;
      check("tick_period", int'(tick), 1);
   endtask

   task automatic do_reset();
      rst = 1;
      spd_vld = 0;
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(pw), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_armed", int'(armd), 0);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      model_reset();
      check("first_tick", int'(tick), 1);
   endtask

   initial begin
      int ap, sp;
      bit na;
      rst = 0;
      arm = 0;
      spd_vld = 0;
      sel = 0;
      frnt = 11'h100;
      bck = 11'h100;
      lft = 11'h100;
      rght = 11'h100;
      #2;
      do_reset();
      repeat (5) run_frame(-1, 0, -1, 0);
      sv = '{10, 10, 10, 10};
      run_frame(77, 1, 30, 0);
      repeat (4) run_frame(-1, 1, -1, 0);
      sv = '{40, 10, 10, 10};
      run_frame(-1, 1, 199, 0);
      run_frame(5, 0, -1, 0);
      run_frame(-1, 0, -1, 0);
      for (int n = 0; n < 16; n++) begin
         ap = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 199));
         na = $urandom_range(0, 3) != 0;
         sp = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 199));
         for (int i = 0; i < 4; i++)
            sv[i] = $urandom_range(0, 1) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 2047));
         run_frame(ap, na, sp, 1);
      end
      arm = 1;
      for (int n = 0; n < 4 && nb <= AF; n++) run_frame(-1, 1, -1, 0);
      sv = '{10, 10, 10, 10};
      run_frame(-1, 1, 50, 0);
      repeat (10) @(negedge clk);
      check("pre_rst_pwm", int'(pw), 15);
      rst = 1;
      #1 check("rst_async_pwm", int'(pw), 0);
      do_reset();
      repeat (4) run_frame(-1, 1, -1, 0);
      sel = 1;
      do_reset();
      repeat (4) run_frame(-1, 1, -1, 0);
      sv = '{0, 1, 5, 2047};
      run_frame(-1, 1, 1000, 0);
      run_frame(-1, 1, -1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
